uart_rx_word_packer: RTL and testbench
======================================

// Module: uart_rx_word_packer
// PURPOSE
//   Sits between the UART byte receiver and the 32-bit RX word FIFO of the UART word link.
//   Packs consecutive received bytes, little-endian, into one WORD_WIDTH word and writes it to the FIFO.
//   Discards partial words on a frame error or inter-byte timeout, so a lost byte cannot skew later words.
//   Back-pressures against FIFO full by holding one completed word; bytes arriving meanwhile are dropped and flagged.
// PARAMETERS
//   WORD_WIDTH     32           output word width; must be a multiple of BYTE_WIDTH
//   BYTE_WIDTH     8            UART byte width
//   CLK_FREQ       200_000_000  clock frequency in Hz
//   BAUD_RATE      115200       UART baud rate
//   TIMEOUT_BYTES  4            inter-byte gap, in 10-bit character times, that flushes a partial word
//   localparam BYTES_PER_WORD = WORD_WIDTH/BYTE_WIDTH (4)
//   localparam TIMEOUT_CYCLES = TIMEOUT_BYTES*10*(CLK_FREQ/BAUD_RATE) (= 69440 at defaults)
// PORTS
//   clock         in   1           system clock, rising edge
//   reset         in   1           asynchronous, active-low reset
//   rx_valid      in   1           1-cycle pulse: rx_data holds a received byte
//   rx_data       in   BYTE_WIDTH  received byte
//   rx_frame_err  in   1           1-cycle pulse: bad stop bit on the current/last byte
//   fifo_full     in   1           RX word FIFO is full
//   word_write    out  1           1-cycle FIFO write strobe
//   word_data     out  WORD_WIDTH  packed word; valid while word_write=1
//   byte_count    out  2           bytes collected toward the current word (0..BYTES_PER_WORD-1)
//   overflow      out  1           sticky: a byte was dropped during HOLD
//   timeout_flush out  1           1-cycle pulse: a partial word was discarded on timeout
//   clear_flags   in   1           synchronous clear of overflow
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE. word_write, word_data, byte_count, overflow, timeout_flush and the timer all 0.
//   Packing: byte k (0-based) of a word goes to word_data[k*BYTE_WIDTH +: BYTE_WIDTH].
//   States:
//     IDLE    byte_count=0, timer off. rx_valid&!rx_frame_err -> store byte 0, byte_count=1, go to COLLECT.
//     COLLECT rx_valid&!err stores the next byte and reloads the timer to 0.
//             On the last byte: if !fifo_full, word_write=1 on the next cycle and go to IDLE.
//             If fifo_full, go to HOLD.
//             Timer reaches TIMEOUT_CYCLES with no byte: discard, pulse timeout_flush, go to IDLE.
//     HOLD    word_data is held stable. First cycle with fifo_full=0: word_write=1 for 1 cycle, then go to IDLE.
//             rx_valid while in HOLD: byte dropped, overflow<=1. No timeout in HOLD.
//   Latency: word_write is asserted exactly 1 cycle after the rx_valid of the last byte (FIFO not full).
//   fifo_full is sampled in the cycle the last byte arrives. word_write never asserts while fifo_full=1.
//   rx_frame_err=1 (with or without rx_valid), in IDLE or COLLECT:
//     current byte and any partial word discarded; byte_count=0; go to IDLE; no flag.
//     A frame error in HOLD is ignored; the held word is kept.
//   rx_valid in the same cycle the timer expires: the byte is accepted and the timer reloads; no flush.
//   clear_flags and an overflow event in the same cycle: overflow=1 (set wins).
//   Timer: width $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
//   byte_count wraps 3 -> 0 on word completion.
//   Reset mid-word or in HOLD: the partial or held word is lost; no write occurs.
// TESTING
//   1. Bytes DD,CC,BB,AA, fifo_full=0 -> one word_write pulse, word_data=32'hAABBCCDD, 1 cycle after the 4th byte.
//   2. Bytes 68,65 then a gap of 69440 cycles -> timeout_flush pulse, byte_count=0.
//      Then 6C,6C,6F,09 -> word 32'h096F6C6C.
//   3. Bytes 01,02 then rx_frame_err -> byte_count=0, no write.
//      Then 11,22,33,44 -> word 32'h44332211.
//   4. fifo_full=1 at the 4th byte of 10,20,30,40, plus one extra byte in HOLD -> overflow=1, no write.
//      Release fifo_full -> one write of 32'h40302010. clear_flags -> overflow=0.
//   5. Assert reset in the middle of byte 3 -> all outputs 0 asynchronously.
//      After release, 4 bytes -> a single correct word.
//   6. 64 back-to-back words at the baud rate, against a 64-deep FIFO model -> all words in order, overflow=0.

Source files
------------

// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer: packs received UART bytes little-endian into words for the RX word FIFO
module uart_rx_word_packer #(
  parameter int WORD_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int CLK_FREQ      = 200_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        rx_valid,
  input  logic [BYTE_WIDTH-1:0]                       rx_data,
  input  logic                                        rx_frame_err,
  input  logic                                        fifo_full,
  input  logic                                        clear_flags,
  output logic                                        word_write,
  output logic [WORD_WIDTH-1:0]                       word_data,
  output logic [$clog2(WORD_WIDTH/BYTE_WIDTH)-1:0]    byte_count,
  output logic                                        overflow,
  output logic                                        timeout_flush
);
  localparam int BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt_d;
  logic [WORD_WIDTH-1:0] data_d;
  logic [TW-1:0] timer, timer_d;
  logic wr_q, wr_d, ovf_d, flush_d;
  logic last;
  assign last = byte_count == CW'(BYTES_PER_WORD - 1);
  // A held word is written in the same cycle the FIFO frees up, so no write ever lands on a full FIFO
  assign word_write = wr_q | (state == HOLD && !fifo_full);
  // Next-state logic: frame errors and timeouts drop partial words, HOLD drops incoming bytes
  always_comb begin
    state_d = state;
    cnt_d   = byte_count;
    data_d  = word_data;
    timer_d = timer;
    wr_d    = 1'b0;
    flush_d = 1'b0;
    ovf_d   = overflow & ~clear_flags;
    if (state == HOLD) begin
      state_d = fifo_full ? HOLD : IDLE;
      ovf_d   = ovf_d | rx_valid;
    end else if (rx_frame_err) begin
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else if (rx_valid) begin
      data_d[int'(byte_count)*BYTE_WIDTH +: BYTE_WIDTH] = rx_data;
      cnt_d   = byte_count + 1'b1;
      timer_d = '0;
      state_d = !last ? COLLECT : fifo_full ? HOLD : IDLE;
      wr_d    = last & ~fifo_full;
    end else if (state == COLLECT) begin
      flush_d = timer == TW'(TIMEOUT_CYCLES);
      state_d = flush_d ? IDLE : COLLECT;
      cnt_d   = flush_d ? '0 : byte_count;
      timer_d = flush_d ? '0 : timer + 1'b1;
    end
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      byte_count    <= '0;
      word_data     <= '0;
      timer         <= '0;
      wr_q          <= 1'b0;
      overflow      <= 1'b0;
      timeout_flush <= 1'b0;
    end else begin
      state         <= state_d;
      byte_count    <= cnt_d;
      word_data     <= data_d;
      timer         <= timer_d;
      wr_q          <= wr_d;
      overflow      <= ovf_d;
      timeout_flush <= flush_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// tb_uart_rx_word_packer: directed scoreboard bench for the UART RX word packer
module tb_uart_rx_word_packer;
  localparam int CLK_FREQ = 1_152_000;
  localparam int BAUD     = 115200;
  localparam int CHAR     = 10 * (CLK_FREQ / BAUD);
  localparam int TC       = 4 * CHAR;
  logic clock = 0, reset = 0, rx_valid = 0, rx_frame_err = 0, full_force = 0, clear_flags = 0;
  logic use_model = 0;
  logic [7:0] rx_data = 0;
  logic fifo_full, word_write, overflow, timeout_flush;
  logic [31:0] word_data;
  logic [1:0] byte_count;
  int checks = 0, failures = 0, writes = 0, fifo_cnt = 0;
  logic [31:0] exp_q[$];
  assign fifo_full = use_model ? (fifo_cnt >= 64) : full_force;
  always #5 clock = ~clock;
  uart_rx_word_packer #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .fifo_full(fifo_full), .clear_flags(clear_flags),
    .word_write(word_write), .word_data(word_data), .byte_count(byte_count),
    .overflow(overflow), .timeout_flush(timeout_flush));
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(logic [7:0] b);
    @(posedge clock); #1;
    rx_valid = 1; rx_data = b;
    @(posedge clock); #1;
    rx_valid = 0;
  endtask
  task automatic frame_err();
    @(posedge clock); #1;
    rx_frame_err = 1;
    @(posedge clock); #1;
    rx_frame_err = 0;
  endtask
  // Every FIFO write is matched against the oldest expected word
  always @(negedge clock) begin
    if (reset && word_write) begin
      writes++;
      check("write_while_full", fifo_full, 0);
      check("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("word_data", word_data, exp_q.pop_front());
      if (use_model) fifo_cnt++;
    end
  end
  initial begin
    int w0, n;
    logic [31:0] word;
    repeat (2) @(posedge clock);
    #1;
    check("rst_word_write", word_write, 0);
    check("rst_word_data", word_data, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout_flush", timeout_flush, 0);
    reset = 1;
    // 1: basic packing and one-cycle latency
    w0 = writes;
    exp_q.push_back(32'hAABBCCDD);
    send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB);
    check("t1_byte_count3", byte_count, 3);
    send_byte(8'hAA);
    @(negedge clock);
    check("t1_latency", word_write, 1);
    check("t1_byte_count_wrap", byte_count, 0);
    @(negedge clock);
    check("t1_single_pulse", word_write, 0);
    check("t1_writes", writes - w0, 1);
    // 2: inter-byte timeout discards the partial word
    w0 = writes;
    send_byte(8'h68); send_byte(8'h65);
    check("t2_byte_count2", byte_count, 2);
    n = 0;
    while (!timeout_flush && n < TC + 10) begin
      @(posedge clock); #1;
      n++;
    end
    check("t2_flush_seen", timeout_flush, 1);
    check("t2_flush_not_early", 32'(n >= TC && n <= TC + 2), 1);
    check("t2_byte_count0", byte_count, 0);
    @(posedge clock); #1;
    check("t2_flush_pulse", timeout_flush, 0);
    exp_q.push_back(32'h096F6C6C);
    send_byte(8'h6C); send_byte(8'h6C); send_byte(8'h6F); send_byte(8'h09);
    repeat (2) @(negedge clock);
    check("t2_writes", writes - w0, 1);
    // 3: frame error drops the partial word
    w0 = writes;
    send_byte(8'h01); send_byte(8'h02);
    frame_err();
    check("t3_byte_count0", byte_count, 0);
    check("t3_no_write", writes - w0, 0);
    exp_q.push_back(32'h44332211);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(negedge clock);
    check("t3_writes", writes - w0, 1);
    // 4: FIFO full holds the word; extra byte sets overflow
    w0 = writes;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    full_force = 1;
    send_byte(8'h40);
    @(negedge clock);
    check("t4_no_write_full", word_write, 0);
    send_byte(8'h55);
    check("t4_overflow", overflow, 1);
    frame_err();
    repeat (5) @(posedge clock);
    #1;
    check("t4_held_no_write", writes - w0, 0);
    check("t4_held_data", word_data, 32'h40302010);
    exp_q.push_back(32'h40302010);
    full_force = 0;
    @(negedge clock);
    check("t4_release_write", word_write, 1);
    repeat (2) @(negedge clock);
    check("t4_writes", writes - w0, 1);
    @(posedge clock); #1;
    clear_flags = 1;
    @(posedge clock); #1;
    clear_flags = 0;
    check("t4_clear", overflow, 0);
    // 5: async reset in the middle of byte 3
    w0 = writes;
    send_byte(8'hA0); send_byte(8'hB0);
    @(posedge clock); #1;
    rx_valid = 1; rx_data = 8'hC0;
    #2 reset = 0;
    #1;
    check("t5_async_byte_count", byte_count, 0);
    check("t5_async_word_data", word_data, 0);
    check("t5_async_word_write", word_write, 0);
    check("t5_async_overflow", overflow, 0);
    @(posedge clock); #1;
    rx_valid = 0;
    @(posedge clock); #1;
    reset = 1;
    exp_q.push_back(32'hD4C3B2A1);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    repeat (2) @(negedge clock);
    check("t5_writes", writes - w0, 1);
    // 6: 64 words at the baud rate into a 64-deep FIFO model
    w0 = writes;
    fifo_cnt = 0;
    use_model = 1;
    for (int w = 0; w < 64; w++) begin
      word = $urandom;
      exp_q.push_back(word);
      for (int b = 0; b < 4; b++) begin
        send_byte(word[8*b +: 8]);
        repeat (CHAR - 2) @(posedge clock);
      end
    end
    repeat (4) @(negedge clock);
    check("t6_writes", writes - w0, 64);
    check("t6_fifo_cnt", fifo_cnt, 64);
    check("t6_scoreboard_drained", exp_q.size(), 0);
    check("t6_overflow", overflow, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
